// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative unsigned multiply,
// divide and remainder, with valid/ready handshakes on both sides and registered results.
module alu_mc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             S,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int unsigned CNTW = $clog2(WIDTH) + 1;
  localparam int unsigned SHW  = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 s_q, s_d, z_q, z_d, c_q, c_d, v_q, v_d;

  logic                 accept, wr;
  logic [WIDTH-1:0]     fin_res;
  logic                 fin_c, fin_v;

  // Single-cycle datapath, evaluated on the live request operands.
  logic [WIDTH:0]       sum, dif, shl, shr, sra;
  logic [2*WIDTH-1:0]   rot;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_c, sc_v;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} - {1'b0, b};
    shl    = {1'b0, a} << b;
    shr    = {a, 1'b0} >> b;
    sra    = $signed({a, 1'b0}) >>> b;
    rot    = {a, a} << b[SHW-1:0];
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op)
      4'd0: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1, 4'd5: begin
        sc_res = dif[WIDTH-1:0];
        sc_c   = dif[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:                sc_res = a & b;
      4'd3:                sc_res = a | b;
      4'd4:                sc_res = a ^ b;
      4'd6, 4'd7, 4'd12:   sc_res = sum[WIDTH-1:0];
      4'd8:                {sc_c, sc_res} = shl;
      4'd9:                sc_res = rot[2*WIDTH-1:WIDTH];
      4'd10:               {sc_res, sc_c} = shr;
      4'd11:               {sc_res, sc_c} = sra;
      default: ;
    endcase
  end

  // Iteration step: acc holds {high, multiplier} for multiply, {remainder, quotient} for divide.
  logic [WIDTH:0]       mul_sum, rem_sh, rem_dif;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    rem_dif = rem_sh - {1'b0, b_q};
    if (rem_sh >= {1'b0, b_q}) begin
      div_nxt = {rem_dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign res       = res_q;
  assign S         = s_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign V         = v_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    s_d     = s_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    wr      = 1'b0;
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if ((state_q == StDone) && out_ready) state_d = StIdle;
        if (accept) begin
          if (op >= 4'd13) begin
            state_d = StBusy;
            op_d    = op;
            a_d     = a;
            b_d     = b;
            cnt_d   = '0;
            acc_d   = (op == 4'd13) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
          end else begin
            state_d = StDone;
            wr      = 1'b1;
            fin_res = sc_res;
            fin_c   = sc_c;
            fin_v   = sc_v;
          end
        end
      end
      StBusy: begin
        acc_d = (op_q == 4'd13) ? mul_nxt : div_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
          wr      = 1'b1;
          if (op_q == 4'd13) begin
            fin_res = mul_nxt[WIDTH-1:0];
            fin_c   = |mul_nxt[2*WIDTH-1:WIDTH];
          end else begin
            // b=0 naturally yields all-ones quotient and remainder=a in restoring division.
            fin_res = (op_q == 4'd14) ? div_nxt[WIDTH-1:0] : div_nxt[2*WIDTH-1:WIDTH];
            fin_v   = (b_q == '0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (wr) begin
      res_d = fin_res;
      s_d   = fin_res[WIDTH-1];
      z_d   = (fin_res == '0);
      c_d   = fin_c;
      v_d   = fin_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      s_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      s_q     <= s_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

endmodule
